// File: rtl/branch_cc_unit.sv
// Condition-code register plus ID-stage branch/CALL/JMPL resolution with SPARC delay-slot annulment.
// Optional macro CC_BYPASS_EN: forward EX flags to the branch instead of stalling on a CC hazard.
module branch_cc_unit #(
  parameter logic [3:0] CC_RESET = 4'b0000
) (
  input  logic       Clk,
  input  logic       R,
  input  logic       ID_B_instr,
  input  logic [3:0] ID_cond,
  input  logic       ID_29_a,
  input  logic       ID_Call_instr,
  input  logic       ID_jmpl_instr,
  input  logic       EX_modifyCC,
  input  logic [3:0] EX_cc_in,
  output logic [3:0] cc_q,
  output logic       carry_q,
  output logic [1:0] PC_sel,
  output logic       branch_taken,
  output logic       annul_slot,
  output logic       stall
);

  // annul_slot is a direct decode of state, so it doubles as the FSM debug view.
  typedef enum logic {NORMAL = 1'b0, ANNUL = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [3:0] cc_eff;
  logic       flag_n, flag_z, flag_v, flag_c;
  logic       cond_base;
  logic       cond_true;

  always_ff @(posedge Clk) begin
    if (R) begin
      cc_q <= CC_RESET;
    end else if (EX_modifyCC) begin
      cc_q <= EX_cc_in;
    end
  end

  assign carry_q = cc_q[0];

`ifdef CC_BYPASS_EN
  assign cc_eff = EX_modifyCC ? EX_cc_in : cc_q;
  assign stall  = 1'b0;
`else
  assign cc_eff = cc_q;
  // One-cycle hold: the bubble guarantees EX_modifyCC is clear on the retry.
  assign stall  = ID_B_instr & EX_modifyCC & ~annul_slot;
`endif

  assign {flag_n, flag_z, flag_v, flag_c} = cc_eff;

  // cond[3] inverts the sense of the base test encoded in cond[2:0].
  always_comb begin
    cond_base = 1'b0;
    case (ID_cond[2:0])
      3'b000: cond_base = 1'b0;
      3'b001: cond_base = flag_z;
      3'b010: cond_base = flag_z | (flag_n ^ flag_v);
      3'b011: cond_base = flag_n ^ flag_v;
      3'b100: cond_base = flag_c | flag_z;
      3'b101: cond_base = flag_c;
      3'b110: cond_base = flag_n;
      3'b111: cond_base = flag_v;
      default: cond_base = 1'b0;
    endcase
  end

  assign cond_true = ID_cond[3] ^ cond_base;

  always_ff @(posedge Clk) begin
    if (R) begin
      state <= NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = NORMAL;
    annul_slot   = (state == ANNUL);
    PC_sel       = 2'b00;
    branch_taken = 1'b0;
    if (!annul_slot && !stall) begin
      branch_taken = ID_B_instr & cond_true;
      if (ID_Call_instr) begin
        PC_sel = 2'b10;
      end else if (ID_jmpl_instr) begin
        PC_sel = 2'b11;
      end else if (ID_B_instr && cond_true) begin
        PC_sel = 2'b01;
      end
      // BA,a annuls its slot even though taken; other taken branches keep it.
      if (ID_B_instr && ID_29_a && ((ID_cond == 4'b1000) || !cond_true)) begin
        state_nxt = ANNUL;
      end
    end
  end

endmodule

// File: tb/tb_branch_cc_unit.sv
// Directed bench for branch_cc_unit: literal checks plus a per-cycle flag/annul model compare.
`timescale 1ns/1ps
module tb_branch_cc_unit;

  logic       Clk = 1'b0;
  logic       R = 1'b0;
  logic       ID_B_instr = 1'b0;
  logic [3:0] ID_cond = 4'b0000;
  logic       ID_29_a = 1'b0;
  logic       ID_Call_instr = 1'b0;
  logic       ID_jmpl_instr = 1'b0;
  logic       EX_modifyCC = 1'b0;
  logic [3:0] EX_cc_in = 4'b0000;
  logic [3:0] cc_q;
  logic       carry_q;
  logic [1:0] PC_sel;
  logic       branch_taken;
  logic       annul_slot;
  logic       stall;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  branch_cc_unit #(.CC_RESET(4'b0000)) dut (
    .Clk(Clk), .R(R), .ID_B_instr(ID_B_instr), .ID_cond(ID_cond), .ID_29_a(ID_29_a),
    .ID_Call_instr(ID_Call_instr), .ID_jmpl_instr(ID_jmpl_instr),
    .EX_modifyCC(EX_modifyCC), .EX_cc_in(EX_cc_in), .cc_q(cc_q), .carry_q(carry_q),
    .PC_sel(PC_sel), .branch_taken(branch_taken), .annul_slot(annul_slot), .stall(stall)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_cc;
  logic       m_annul;
  logic       m_valid = 1'b0;
  logic [3:0] exp_q[$];

  function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c;
    {n, z, v, c} = f;
    case (cond)
      4'b1000: return 1'b1;
      4'b0000: return 1'b0;
      4'b1001: return !z;
      4'b0001: return z;
      4'b1010: return !(z || (n != v));
      4'b0010: return z || (n != v);
      4'b1011: return n == v;
      4'b0011: return n != v;
      4'b1100: return !(c || z);
      4'b0100: return c || z;
      4'b1101: return !c;
      4'b0101: return c;
      4'b1110: return !n;
      4'b0110: return n;
      4'b1111: return !v;
      default: return v;
    endcase
  endfunction

  function automatic logic [3:0] m_flags();
`ifdef CC_BYPASS_EN
    if (EX_modifyCC) return EX_cc_in;
`endif
    return m_cc;
  endfunction

  function automatic logic m_stall();
`ifdef CC_BYPASS_EN
    return 1'b0;
`else
    return ID_B_instr && EX_modifyCC && !m_annul;
`endif
  endfunction

  always @(posedge Clk) begin
    if (R) begin
      m_cc    <= 4'b0000;
      m_annul <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      m_annul <= !m_annul && !m_stall() && ID_B_instr && ID_29_a &&
                 (ID_cond == 4'b1000 || !holds(ID_cond, m_flags()));
      if (EX_modifyCC) m_cc <= EX_cc_in;
    end
  end

  // Scoreboard: expected {PC_sel, taken, stall} pushed and popped each meaningful cycle.
  always @(negedge Clk) begin
    logic       live;
    logic [3:0] e;
    logic [3:0] got;
    if (m_valid) begin
      live = !m_annul && !m_stall();
      e[3:2] = !live ? 2'b00 : ID_Call_instr ? 2'b10 : ID_jmpl_instr ? 2'b11 :
               (ID_B_instr && holds(ID_cond, m_flags())) ? 2'b01 : 2'b00;
      e[1] = live && ID_B_instr && holds(ID_cond, m_flags());
      e[0] = m_stall();
      exp_q.push_back(e);
      got = {PC_sel, branch_taken, stall};
      chk("model_sel_taken_stall", got, exp_q.pop_front());
      chk("model_cc_q", cc_q, m_cc);
      chk("model_carry", {3'b000, carry_q}, {3'b000, m_cc[0]});
      chk("model_annul", {3'b000, annul_slot}, {3'b000, m_annul});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    ID_B_instr = 0; ID_29_a = 0; ID_Call_instr = 0; ID_jmpl_instr = 0; EX_modifyCC = 0;
  endtask

  task automatic load_cc(input logic [3:0] v);
    idle(); EX_modifyCC = 1; EX_cc_in = v;
    cyc();
    EX_modifyCC = 0;
  endtask

  task automatic branch(input logic [3:0] cond, input logic a);
    idle(); ID_B_instr = 1; ID_cond = cond; ID_29_a = a;
  endtask

  task automatic look(input string name, input logic [1:0] pc, input logic tk, input logic an);
    @(negedge Clk);
    chk({name, "_pc"}, {2'b00, PC_sel}, {2'b00, pc});
    chk({name, "_taken"}, {3'b000, branch_taken}, {3'b000, tk});
    chk({name, "_annul"}, {3'b000, annul_slot}, {3'b000, an});
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    R = 1; EX_modifyCC = 1; EX_cc_in = 4'b1111;
    cyc(); cyc();
    look("reset", 2'b00, 0, 0);
    chk("reset_cc", cc_q, 4'b0000);
    cyc();
    R = 0;
    load_cc(4'b0100);

    branch(4'b0001, 0); look("be_z1", 2'b01, 1, 0); cyc();
    branch(4'b1001, 0); look("bne_z1", 2'b00, 0, 0); cyc();
    branch(4'b0100, 0); look("bleu_z1", 2'b01, 1, 0); cyc();

    load_cc(4'b0000);
    branch(4'b0001, 1); look("be_a_untaken", 2'b00, 0, 0); cyc();
    idle(); ID_Call_instr = 1; look("annulled_call", 2'b00, 0, 1); cyc();
    idle(); look("after_annul", 2'b00, 0, 0); cyc();

    branch(4'b1000, 1); look("ba_a", 2'b01, 1, 0); cyc();
    branch(4'b1000, 1); look("ba_in_slot", 2'b00, 0, 1); cyc();
    idle(); look("slot_branch_ignored", 2'b00, 0, 0); cyc();
    load_cc(4'b0100);
    branch(4'b0001, 1); look("be_a_taken", 2'b01, 1, 0); cyc();
    idle(); look("be_a_no_annul", 2'b00, 0, 0); cyc();

    load_cc(4'b0000);
    branch(4'b0001, 0); EX_modifyCC = 1; EX_cc_in = 4'b0100;
`ifdef CC_BYPASS_EN
    look("hazard_bypass", 2'b01, 1, 0);
    chk("hazard_stall", {3'b000, stall}, 4'b0000);
`else
    look("hazard_hold", 2'b00, 0, 0);
    chk("hazard_stall", {3'b000, stall}, 4'b0001);
`endif
    cyc();
    EX_modifyCC = 0; look("hazard_retry", 2'b01, 1, 0);
    chk("hazard_retry_stall", {3'b000, stall}, 4'b0000);
    cyc();

    idle(); ID_Call_instr = 1; look("call", 2'b10, 0, 0); cyc();
    idle(); ID_jmpl_instr = 1; look("jmpl", 2'b11, 0, 0); cyc();

    branch(4'b1000, 1); R = 1; look("ba_a_with_reset", 2'b01, 1, 0); cyc();
    R = 0; idle(); look("reset_blocks_annul", 2'b00, 0, 0); cyc();
    branch(4'b1000, 1); cyc();
    idle(); R = 1; look("in_annul_reset", 2'b00, 0, 1); cyc();
    R = 0; look("annul_cleared", 2'b00, 0, 0);
    chk("reset_cc_again", cc_q, 4'b0000);
    cyc();

    load_cc(4'b0001);
    @(negedge Clk);
    chk("carry_q", {3'b000, carry_q}, 4'b0001);
    cyc();
    branch(4'b0101, 0); look("bcs_c1", 2'b01, 1, 0); cyc();
    branch(4'b1100, 0); look("bgu_c1", 2'b00, 0, 0); cyc();
    idle(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
